// File: rtl/combo_programmer.sv
// combo_programmer: enter three 16-bit words, re-enter them to confirm, then commit
// them to the combo outputs that feed the lock's compare constants.
module combo_programmer #(
    parameter logic [15:0] DEFAULT0       = 16'h0001,
    parameter logic [15:0] DEFAULT1       = 16'hF3CF,
    parameter logic [15:0] DEFAULT2       = 16'h4AA7,
    parameter int          TIMEOUT_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btnl,
    input  logic        btnc,
    input  logic        btnr,
    input  logic [15:0] sw,
    output logic [15:0] combo0,
    output logic [15:0] combo1,
    output logic [15:0] combo2,
    output logic        updated,
    output logic        busy,
    output logic [15:0] led
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    // COMMIT directly follows CONFIRM3 so every forward step is state + 1
    typedef enum logic [3:0] {
        IDLE, ENTER1, ENTER2, ENTER3, CONFIRM1, CONFIRM2, CONFIRM3, COMMIT, ERROR
    } state_t;

    state_t        state;
    logic [2:0]    b_q, b_qq, pulse;
    logic          pr, pc, pl, active, timeout, to_idle;
    logic [1:0]    idx;
    logic [15:0]   stage [3];
    logic [CW-1:0] cnt;

    assign pulse   = b_q & ~b_qq;
    assign pr      = pulse[2];
    assign pc      = pulse[1] & ~pr;
    assign pl      = pulse[0] & ~pulse[1] & ~pr;
    assign active  = state >= ENTER1 && state <= CONFIRM3;
    assign idx     = 2'(state >= CONFIRM1 ? state - CONFIRM1 : state - ENTER1);
    assign timeout = cnt == LAST && pulse == '0;
    assign to_idle = (active && (pr || timeout)) || (state == ERROR && (pr || pc)) || state == COMMIT;
    assign busy    = state != IDLE;

    always_comb begin
        case (state)
            IDLE:     led = 16'h0001;
            ENTER1:   led = 16'h0002;
            ENTER2:   led = 16'h0003;
            ENTER3:   led = 16'h0004;
            CONFIRM1: led = 16'h0005;
            CONFIRM2: led = 16'h0006;
            CONFIRM3: led = 16'h0007;
            ERROR:    led = 16'hAAAA;
            default:  led = 16'hFFFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            b_q     <= '0;
            b_qq    <= '0;
            cnt     <= '0;
            stage   <= '{default: '0};
            combo0  <= DEFAULT0;
            combo1  <= DEFAULT1;
            combo2  <= DEFAULT2;
            updated <= 1'b0;
        end else begin
            b_q     <= {btnr, btnc, btnl};
            b_qq    <= b_q;
            updated <= 1'b0;
            cnt     <= (!active || pulse != '0 || cnt == LAST) ? '0 : cnt + 1'b1;
            if (state == COMMIT) begin
                combo0  <= stage[0];
                combo1  <= stage[1];
                combo2  <= stage[2];
                updated <= 1'b1;
            end
            if (to_idle) begin
                state <= IDLE;
                stage <= '{default: '0};
            end else begin
                case (state)
                    IDLE: if (pl) state <= ENTER1;
                    ENTER1, ENTER2, ENTER3: if (pc) begin
                        stage[idx] <= sw;
                        state      <= state_t'(state + 4'd1);
                    end
                    CONFIRM1, CONFIRM2, CONFIRM3: if (pc)
                        state <= (sw == stage[idx]) ? state_t'(state + 4'd1) : ERROR;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_combo_programmer.sv
// tb_combo_programmer: table vectors, directed corner sequences and randomized
// button traffic checked against a word-list model of the programmer.
module tb_combo_programmer;
    localparam int T = 8;
    localparam int M_IDLE = 0, M_PROG = 1, M_ERR = 2, M_COMMIT = 3;

    logic        clk = 1'b0, reset_n = 1'b0, btnl = 1'b0, btnc = 1'b0, btnr = 1'b0;
    logic [15:0] sw = '0;
    logic [15:0] combo0, combo1, combo2, led;
    logic        updated, busy;

    int total = 0, bad = 0;

    int          m_mode, m_n, m_idle;
    logic [15:0] m_words[$];
    logic [15:0] m_combo[3];
    logic        m_upd;
    logic [2:0]  h1, h2;

    typedef struct {
        logic        l, c, r;
        logic [15:0] s;
        logic [15:0] e_led;
        logic        e_upd;
        logic [15:0] e_c0;
    } vec_t;
    vec_t tbl[16];

    combo_programmer #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset_n(reset_n), .btnl(btnl), .btnc(btnc), .btnr(btnr), .sw(sw),
        .combo0(combo0), .combo1(combo1), .combo2(combo2),
        .updated(updated), .busy(busy), .led(led)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_to_idle();
        m_mode = M_IDLE;
        m_words.delete();
        m_n    = 0;
        m_idle = 0;
    endtask

    task automatic model_reset();
        m_to_idle();
        m_combo = '{16'h0001, 16'hF3CF, 16'h4AA7};
        m_upd   = 1'b0;
        h1      = '0;
        h2      = '0;
    endtask

    function automatic logic [15:0] m_led();
        if (m_mode == M_IDLE) return 16'h0001;
        if (m_mode == M_PROG) return 16'(m_n + 2);
        if (m_mode == M_ERR) return 16'hAAAA;
        return 16'hFFFF;
    endfunction

    task automatic model_step(input logic l, input logic c, input logic r, input logic [15:0] s);
        logic [2:0] p;
        logic pr, pc, pl;
        p  = h1 & ~h2;
        h2 = h1;
        h1 = {r, c, l};
        pr = p[2];
        pc = p[1] && !pr;
        pl = p[0] && !p[1] && !pr;
        m_upd = 1'b0;
        case (m_mode)
            M_IDLE: if (pl) begin
                m_mode = M_PROG;
                m_n    = 0;
                m_idle = 0;
            end
            M_PROG: begin
                if (pr) m_to_idle();
                else if (pc) begin
                    m_idle = 0;
                    if (m_n < 3) begin
                        m_words.push_back(s);
                        m_n++;
                    end else if (s == m_words[m_n-3]) begin
                        m_n++;
                        if (m_n == 6) m_mode = M_COMMIT;
                    end else m_mode = M_ERR;
                end else if (p != 0) m_idle = 0;
                else if (m_idle == T - 1) m_to_idle();
                else m_idle++;
            end
            M_ERR: if (pr || pc) m_to_idle();
            default: begin
                for (int i = 0; i < 3; i++) m_combo[i] = m_words[i];
                m_upd = 1'b1;
                m_to_idle();
            end
        endcase
    endtask

    // drive at negedge, step the model at the edge, compare at the next negedge
    task automatic tick(input logic l, input logic c, input logic r, input logic [15:0] s);
        btnl = l;
        btnc = c;
        btnr = r;
        sw   = s;
        @(posedge clk);
        model_step(l, c, r, s);
        @(negedge clk);
        chk("model", {combo0, combo1, combo2, updated, busy, led},
            {m_combo[0], m_combo[1], m_combo[2], m_upd, m_mode != M_IDLE, m_led()});
    endtask

    task automatic press(input logic l, input logic c, input logic r, input logic [15:0] s);
        tick(l, c, r, s);
        tick(1'b0, 1'b0, 1'b0, s);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        {btnl, btnc, btnr} = 3'b000;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 16'h0000, 16'h0001, 0, 16'h0001};
        tbl[1]  = '{0, 0, 0, 16'h0000, 16'h0002, 0, 16'h0001};
        tbl[2]  = '{0, 1, 0, 16'h1234, 16'h0002, 0, 16'h0001};
        tbl[3]  = '{0, 0, 0, 16'h1234, 16'h0003, 0, 16'h0001};
        tbl[4]  = '{0, 1, 0, 16'h00FF, 16'h0003, 0, 16'h0001};
        tbl[5]  = '{0, 0, 0, 16'h00FF, 16'h0004, 0, 16'h0001};
        tbl[6]  = '{0, 1, 0, 16'hBEEF, 16'h0004, 0, 16'h0001};
        tbl[7]  = '{0, 0, 0, 16'hBEEF, 16'h0005, 0, 16'h0001};
        tbl[8]  = '{0, 1, 0, 16'h1234, 16'h0005, 0, 16'h0001};
        tbl[9]  = '{0, 0, 0, 16'h1234, 16'h0006, 0, 16'h0001};
        tbl[10] = '{0, 1, 0, 16'h00FF, 16'h0006, 0, 16'h0001};
        tbl[11] = '{0, 0, 0, 16'h00FF, 16'h0007, 0, 16'h0001};
        tbl[12] = '{0, 1, 0, 16'hBEEF, 16'h0007, 0, 16'h0001};
        tbl[13] = '{0, 0, 0, 16'hBEEF, 16'hFFFF, 0, 16'h0001};
        tbl[14] = '{0, 0, 0, 16'h0000, 16'h0001, 1, 16'h1234};
        tbl[15] = '{0, 0, 0, 16'h0000, 16'h0001, 0, 16'h1234};

        do_reset();
        chk("reset_defaults", {combo0, combo1, combo2, led, busy, updated},
            {16'h0001, 16'hF3CF, 16'h4AA7, 16'h0001, 1'b0, 1'b0});
        tick(0, 0, 0, 16'h0000);

        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].l, tbl[i].c, tbl[i].r, tbl[i].s);
            chk($sformatf("table_row%0d", i), {led, updated, combo0}, {tbl[i].e_led, tbl[i].e_upd, tbl[i].e_c0});
        end
        chk("full_program_combos", {combo0, combo1, combo2}, {16'h1234, 16'h00FF, 16'hBEEF});

        press(1, 0, 0, 16'h0000);
        press(0, 1, 0, 16'h1111);
        press(0, 1, 0, 16'h2222);
        press(0, 1, 0, 16'h3333);
        press(0, 1, 0, 16'h1111);
        chk("mismatch_first_ok", led, 16'h0006);
        press(0, 1, 0, 16'h2223);
        chk("mismatch_error", led, 16'hAAAA);
        chk("mismatch_combos", {combo0, combo1, combo2}, {16'h1234, 16'h00FF, 16'hBEEF});
        press(0, 1, 0, 16'h0000);
        chk("error_exit", {led, busy}, {16'h0001, 1'b0});

        press(1, 0, 0, 16'h0000);
        press(0, 1, 0, 16'h4444);
        chk("enter2", led, 16'h0003);
        press(0, 1, 1, 16'h5555);
        chk("cancel_priority", {led, updated}, {16'h0001, 1'b0});

        press(1, 0, 0, 16'h0000);
        for (int i = 0; i < 6; i++) tick(0, 1, 0, 16'h7777);
        tick(0, 0, 0, 16'h7777);
        chk("held_btnc_one_advance", led, 16'h0003);
        press(0, 0, 1, 16'h0000);
        chk("cancel_idle", led, 16'h0001);

        press(1, 0, 0, 16'h0000);
        for (int i = 0; i < T - 1; i++) tick(0, 0, 0, 16'h0000);
        chk("timeout_not_yet", led, 16'h0002);
        tick(0, 0, 0, 16'h0000);
        chk("timeout_abort", {led, busy, updated}, {16'h0001, 1'b0, 1'b0});

        press(1, 0, 0, 16'h0000);
        for (int i = 0; i < T - 2; i++) tick(0, 0, 0, 16'h0000);
        tick(0, 1, 0, 16'h9999);
        tick(0, 0, 0, 16'h9999);
        chk("timeout_btnc_wins", led, 16'h0003);
        press(0, 0, 1, 16'h0000);

        press(1, 0, 0, 16'h0000);
        press(0, 1, 0, 16'hCAFE);
        press(0, 1, 0, 16'h0000);
        press(0, 1, 0, 16'h0F0F);
        press(0, 1, 0, 16'hCAFE);
        press(0, 1, 0, 16'h0000);
        press(0, 1, 0, 16'h0F0F);
        chk("in_commit", led, 16'hFFFF);
        reset_n = 1'b0;
        #1;
        chk("reset_mid_commit", {combo0, combo1, combo2, updated, led},
            {16'h0001, 16'hF3CF, 16'h4AA7, 1'b0, 16'h0001});
        do_reset();
        tick(0, 0, 0, 16'h0000);
        chk("after_reset_no_update", {combo0, combo1, combo2, updated},
            {16'h0001, 16'hF3CF, 16'h4AA7, 1'b0});

        for (int i = 0; i < 3000; i++)
            tick($urandom_range(99) < 20, $urandom_range(99) < 35, $urandom_range(99) < 3,
                 $urandom_range(1) == 1 ? 16'h5A5A : 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
